imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 20 ++
 rtl/imem_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
//   Shared definitions for the instruction-memory arbiter: arbiter state
//   encoding, default starvation limit and the RV64 NOP instruction that is
//   returned on a misaligned fetch.
package imem_arbiter_pkg;

  // BOOT: program loader owns the memory, core is held.
  // RUN : core fetches and loader share the memory.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Maximum consecutive loader grants while a fetch is waiting.
  localparam int STARVE_MAX_DEF = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : imem_arbiter_pkg

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Arbitrates a single-port external instruction memory between the core
//   fetch port and the program loader. In BOOT only the loader is served and
//   the core is held; l_done moves to RUN, where the loader has priority but
//   a waiting fetch is guaranteed service after STARVE_MAX loader grants.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   f_req/f_pc                  fetch request and byte address
//   f_gnt/f_rvalid/f_instr/f_err  fetch grant, response valid, data, misalign flag
//   l_req/l_we/l_addr/l_wdata   loader request, write enable, byte address, data
//   l_done                      one-cycle pulse: program load finished
//   l_gnt/l_rvalid/l_rdata      loader grant, readback valid, readback data
//   m_en/m_we/m_addr/m_wdata    memory command (word address)
//   m_rdata                     memory read data, one cycle after an m_en read
//   core_hold                   core stall
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [63:0]       f_pc,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_instr,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [63:0]       l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_done,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              core_hold
);

  // ADDR_W is expected to equal $clog2(MEM_DEPTH); MEM_DEPTH itself only
  // documents the size of the external array.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             f_rvalid_q, f_rvalid_d;
  logic             f_err_q, f_err_d;
  logic             l_rvalid_q, l_rvalid_d;
  logic             core_hold_q, core_hold_d;

  logic run;
  logic f_misal;
  logic l_win;
  logic f_win;

  always_comb begin
    run     = (state_q == ST_RUN);
    f_misal = (f_pc[1:0] != 2'b00);

    // Loader wins ties in RUN unless fetch has been starved to the limit.
    // Nothing is granted while rst is high, so a reset cycle never leaves a
    // response behind.
    l_win = !rst && l_req && (!run || !f_req || (starve_q != STARVE_LIM));
    f_win = !rst && run && f_req && !l_win;

    f_gnt   = f_win;
    l_gnt   = l_win;
    // A misaligned fetch is accepted but never touches the memory.
    m_en    = l_win || (f_win && !f_misal);
    m_we    = l_win && l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (l_win) begin
      m_addr = l_addr[ADDR_W+1:2];
      if (l_we) m_wdata = l_wdata;
    end else if (f_win && !f_misal) begin
      m_addr = f_pc[ADDR_W+1:2];
    end

    // Next-state values.
    state_d = state_q;
    if (!run && l_done) state_d = ST_RUN;
    core_hold_d = (state_d == ST_BOOT);

    starve_d = starve_q;
    if (f_win || !f_req) begin
      starve_d = '0;
    end else if (l_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end

    f_rvalid_d = f_win;
    f_err_d    = f_win && f_misal;
    l_rvalid_d = l_win && !l_we;

    // Responses are masked during rst so that a pending read is dropped.
    f_rvalid  = f_rvalid_q && !rst;
    f_err     = f_err_q && f_rvalid;
    f_instr   = '0;
    if (f_rvalid) f_instr = f_err_q ? NOP_INSTR : m_rdata;
    l_rvalid  = l_rvalid_q && !rst;
    l_rdata   = l_rvalid ? m_rdata : 32'h0;
    core_hold = core_hold_q || rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      starve_q    <= '0;
      f_rvalid_q  <= 1'b0;
      f_err_q     <= 1'b0;
      l_rvalid_q  <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      f_rvalid_q  <= f_rvalid_d;
      f_err_q     <= f_err_d;
      l_rvalid_q  <= l_rvalid_d;
      core_hold_q <= core_hold_d;
    end
  end

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Directed test of imem_arbiter with a small behavioural memory attached.
module tb_imem_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req;
  logic [63:0]       f_pc;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_instr;
  logic              f_err;
  logic              l_req;
  logic              l_we;
  logic [63:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_done;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              core_hold;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  imem_arbiter #(
    .MEM_DEPTH (1024),
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_pc     (f_pc),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_instr  (f_instr),
    .f_err    (f_err),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_done   (l_done),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  // External single-port memory: registered read, write on enable.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cyc=%0d %s: got 0x%0h expected 0x%0h", cyc, tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs shortly after the rising edge, then wait until
  // the combinational outputs have settled, well before the next edge.
  task automatic step(input logic r, input logic fr, input logic [63:0] pc,
                      input logic lr, input logic we, input logic [63:0] la,
                      input logic [31:0] wd, input logic ld);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; f_req = fr; f_pc = pc;
    l_req = lr; l_we = we; l_addr = la; l_wdata = wd; l_done = ld;
    #3;
    $display("cyc %0d rst=%0b f_req=%0b f_pc=0x%0h l_req=%0b l_we=%0b l_addr=0x%0h | f_gnt=%0b l_gnt=%0b m_en=%0b m_addr=%0d f_rv=%0b f_instr=0x%0h f_err=%0b l_rv=%0b l_rdata=0x%0h hold=%0b",
             cyc, r, fr, pc, lr, we, la, f_gnt, l_gnt, m_en, m_addr,
             f_rvalid, f_instr, f_err, l_rvalid, l_rdata, core_hold);
  endtask

  // Expected grant pattern for six cycles of contention: L,L,L,L,F,L.
  logic [5:0] exp_l = 6'b101111;  // bit i = loader granted in contention cycle i

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    m_rdata = 32'h0;
    rst = 1'b1; f_req = 1'b0; f_pc = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_done = 1'b0;

    // Reset with both requesters active: nothing may be granted.
    step(1, 1, 64'h0, 1, 0, 64'h8, 32'h0, 0);
    step(1, 1, 64'h0, 1, 0, 64'h8, 32'h0, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_f_gnt", f_gnt, 0);
    check("rst_l_gnt", l_gnt, 0);
    check("rst_m_en", m_en, 0);
    check("rst_l_rvalid", l_rvalid, 0);
    check("rst_f_rvalid", f_rvalid, 0);

    // BOOT: loader write 0xDEADBEEF at 0x8 while fetch is ignored.
    step(0, 1, 64'h0, 1, 1, 64'h8, 32'hDEADBEEF, 0);
    check("boot_wr_l_gnt", l_gnt, 1);
    check("boot_wr_f_gnt", f_gnt, 0);
    check("boot_wr_m_we", m_we, 1);
    check("boot_wr_m_addr", m_addr, 2);
    check("boot_wr_m_wdata", m_wdata, 32'hDEADBEEF);
    check("boot_wr_hold", core_hold, 1);

    // Readback of the same word right after the write.
    step(0, 1, 64'h0, 1, 0, 64'h8, 32'h0, 0);
    check("boot_rd_l_gnt", l_gnt, 1);
    check("boot_rd_m_we", m_we, 0);
    check("boot_wr_no_rvalid", l_rvalid, 0);

    step(0, 1, 64'h0, 0, 0, 64'h0, 32'h0, 0);
    check("boot_rd_l_rvalid", l_rvalid, 1);
    check("boot_rd_l_rdata", l_rdata, 32'hDEADBEEF);
    check("boot_idle_m_en", m_en, 0);
    check("boot_f_gnt", f_gnt, 0);
    check("boot_hold", core_hold, 1);

    // l_done pulse; still BOOT this cycle.
    step(0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 1);
    check("done_hold", core_hold, 1);
    check("done_l_rvalid_clr", l_rvalid, 0);
    check("done_l_rdata_zero", l_rdata, 0);

    // RUN: lone fetch granted immediately.
    step(0, 1, 64'h8, 0, 0, 64'h0, 32'h0, 0);
    check("run_hold", core_hold, 0);
    check("run_f_gnt", f_gnt, 1);
    check("run_f_m_en", m_en, 1);
    check("run_f_m_addr", m_addr, 2);

    step(0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 0);
    check("run_f_rvalid", f_rvalid, 1);
    check("run_f_instr", f_instr, 32'hDEADBEEF);
    check("run_f_err", f_err, 0);

    // Contention for six cycles.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 64'h0, 1, 0, 64'h0, 32'h0, 0);
      check($sformatf("cont%0d_l_gnt", i), l_gnt, exp_l[i]);
      check($sformatf("cont%0d_f_gnt", i), f_gnt, !exp_l[i]);
    end

    // Misaligned fetch.
    step(0, 1, 64'h6, 0, 0, 64'h0, 32'h0, 0);
    check("mis_f_gnt", f_gnt, 1);
    check("mis_m_en", m_en, 0);

    // Next cycle: error response, plus address wrap-around on 0x1008.
    step(0, 1, 64'h1008, 0, 0, 64'h0, 32'h0, 0);
    check("mis_f_rvalid", f_rvalid, 1);
    check("mis_f_err", f_err, 1);
    check("mis_f_instr", f_instr, 32'h00000013);
    check("wrap_f_gnt", f_gnt, 1);
    check("wrap_m_addr", m_addr, 2);

    // Loader readback grant, then reset on the following cycle.
    step(0, 0, 64'h0, 1, 0, 64'h8, 32'h0, 0);
    check("wrap_f_instr", f_instr, 32'hDEADBEEF);
    check("wrap_f_err", f_err, 0);
    check("pre_rst_l_gnt", l_gnt, 1);

    step(1, 0, 64'h0, 0, 0, 64'h0, 32'h0, 0);
    check("rst_drop_l_rvalid", l_rvalid, 0);
    check("rst_drop_l_rdata", l_rdata, 0);
    check("rst_drop_hold", core_hold, 1);

    // Back in BOOT: fetch ignored, loader read together with l_done.
    step(0, 1, 64'h0, 1, 0, 64'h8, 32'h0, 1);
    check("reboot_hold", core_hold, 1);
    check("reboot_f_gnt", f_gnt, 0);
    check("reboot_l_gnt", l_gnt, 1);
    check("reboot_l_rvalid", l_rvalid, 0);

    step(0, 1, 64'h8, 0, 0, 64'h0, 32'h0, 0);
    check("done_req_l_rvalid", l_rvalid, 1);
    check("done_req_l_rdata", l_rdata, 32'hDEADBEEF);
    check("done_req_run_hold", core_hold, 0);
    check("done_req_f_gnt", f_gnt, 1);

    step(0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 0);
    check("final_f_instr", f_instr, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_arbiter
